// File: rtl/alib_code_packer_if.sv
// Symbol-in / word-out handshake bundle for the code packer.
// slave = packer side, master = producer/consumer side.
interface alib_code_packer_if #(
  parameter int unsigned OUT_W = 32
);
  logic             i_valid;
  logic             o_ready;
  logic [15:0]      i_code;
  logic [3:0]       i_code_len;
  logic             i_flush;
  logic             o_valid;
  logic             i_ready;
  logic [OUT_W-1:0] o_word;
  logic             o_last;
  logic             o_flush_done;
  logic [31:0]      o_bits_total;

  modport slave (
    input  i_valid, i_code, i_code_len, i_flush, i_ready,
    output o_ready, o_valid, o_word, o_last, o_flush_done, o_bits_total
  );

  modport master (
    output i_valid, i_code, i_code_len, i_flush, i_ready,
    input  o_ready, o_valid, o_word, o_last, o_flush_done, o_bits_total
  );
endinterface

// File: rtl/alib_code_packer.sv
// Packs variable-length codes MSB-first into OUT_W-bit words; a flush pads and
// tags the final word, then pulses flush_done and clears the running bit total.
module alib_code_packer #(
  parameter int unsigned OUT_W = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  alib_code_packer_if.slave   bus
);

  localparam int unsigned CODE_W = 16;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned ACC_W  = OUT_W + 15;
  localparam int unsigned FILL_W = $clog2(ACC_W);
  localparam int unsigned SH_W   = $clog2(ACC_W + 1);
  localparam int unsigned TOT_W  = 32;

  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_DONE} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [OUT_W-1:0]   word_q, word_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic [TOT_W-1:0]   total_q, total_d;

  logic               ready_c;
  logic               accept_c;
  logic               slot_c;
  logic               full_c;
  logic [CODE_W-1:0]  len_mask_c;
  logic [ACC_W-1:0]   code_ext_c;
  logic [SH_W-1:0]    shamt_c;

  // Next-state and output-register logic
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    fill_d     = fill_q;
    word_d     = word_q;
    valid_d    = valid_q;
    last_d     = last_q;
    total_d    = total_q;
    ready_c    = 1'b0;
    accept_c   = 1'b0;
    slot_c     = !valid_q || bus.i_ready;
    full_c     = fill_q >= FILL_W'(OUT_W);
    len_mask_c = CODE_W'((17'd1 << bus.i_code_len) - 17'd1);
    code_ext_c = ACC_W'(bus.i_code & len_mask_c);
    // New code lands directly below the bits already held (acc is left-aligned)
    shamt_c    = SH_W'(ACC_W) - SH_W'(fill_q) - SH_W'(bus.i_code_len);

    if (valid_q && bus.i_ready) valid_d = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        ready_c  = !full_c;
        accept_c = bus.i_valid && ready_c;
        if (accept_c) begin
          acc_d   = acc_q | (code_ext_c << shamt_c);
          fill_d  = fill_q + FILL_W'(bus.i_code_len);
          total_d = total_q + TOT_W'(bus.i_code_len);
        end else if (full_c && slot_c) begin
          word_d  = acc_q[ACC_W-1 -: OUT_W];
          valid_d = 1'b1;
          last_d  = 1'b0;
          acc_d   = acc_q << OUT_W;
          fill_d  = fill_q - FILL_W'(OUT_W);
        end
        if (bus.i_flush) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (full_c && slot_c) begin
          word_d  = acc_q[ACC_W-1 -: OUT_W];
          valid_d = 1'b1;
          last_d  = (fill_q == FILL_W'(OUT_W));
          acc_d   = acc_q << OUT_W;
          fill_d  = fill_q - FILL_W'(OUT_W);
        end else if ((fill_q != '0) && slot_c) begin
          // Bits below fill are always zero, so the top slice is already padded
          word_d  = acc_q[ACC_W-1 -: OUT_W];
          valid_d = 1'b1;
          last_d  = 1'b1;
          acc_d   = '0;
          fill_d  = '0;
        end else if ((fill_q == '0) && (!valid_q || (bus.i_ready && last_q))) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        total_d = '0;
        acc_d   = '0;
        fill_d  = '0;
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_RUN;
      acc_q   <= '0;
      fill_q  <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      total_q <= total_d;
    end
  end

  assign bus.o_ready      = ready_c;
  assign bus.o_valid      = valid_q;
  assign bus.o_word       = word_q;
  assign bus.o_last       = last_q;
  assign bus.o_flush_done = (state_q == ST_DONE);
  assign bus.o_bits_total = total_q;

endmodule

// File: tb/tb_alib_code_packer.sv
// Scoreboard bench for alib_code_packer: a bit-queue reference model predicts
// words/last flags and flush totals; a negedge monitor pops and compares.
module tb_alib_code_packer;
  localparam int unsigned OUT_W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alib_code_packer_if #(.OUT_W(OUT_W)) bus ();

  alib_code_packer #(.OUT_W(OUT_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int unsigned      chk_cnt  = 0;
  int unsigned      pass_cnt = 0;
  logic [OUT_W:0]   exp_q[$];
  logic [31:0]      exp_tot[$];
  bit               bitq[$];
  logic [31:0]      m_tot = '0;
  int               hold_cnt = 0;
  int               rdy_mode = 0;
  bit               done_seen = 0;
  bit               stall_prev = 0;
  bit               done_prev = 0;
  logic [OUT_W:0]   prev_out = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: the stream is just a FIFO of bits
  task automatic m_pop_word(input bit is_flush);
    logic [OUT_W-1:0] w = '0;
    bit b;
    for (int i = 0; i < int'(OUT_W); i++) begin
      b = 1'b0;
      if (bitq.size() > 0) b = bitq.pop_front();
      w = {w[OUT_W-2:0], b};
    end
    exp_q.push_back({(is_flush && bitq.size() == 0), w});
  endtask

  task automatic m_flush();
    exp_tot.push_back(m_tot);
    while (bitq.size() > 0) m_pop_word(1'b1);
    m_tot = '0;
  endtask

  task automatic m_accept(input logic [15:0] code, input logic [3:0] len, input bit flush);
    for (int i = int'(len) - 1; i >= 0; i--) bitq.push_back(code[i]);
    m_tot += 32'(len);
    if (flush) m_flush();
    else if (bitq.size() >= int'(OUT_W)) m_pop_word(1'b0);
  endtask

  // Called at posedge+1; returns at posedge+1 after the symbol is taken
  task automatic send(input logic [15:0] code, input logic [3:0] len, input bit flush);
    int n = 0;
    bus.i_valid = 1'b1; bus.i_code = code; bus.i_code_len = len; bus.i_flush = 1'b0;
    while (!bus.o_ready && n < 300) begin @(posedge clk); #1; n++; end
    if (!bus.o_ready) begin
      chk_cnt++;
      $display("FAIL accept_timeout: got o_ready=0 expected 1 within 300 cycles");
      bus.i_valid = 1'b0;
      return;
    end
    bus.i_flush = flush;
    if (flush) done_seen = 1'b0;
    m_accept(code, len, flush);
    @(posedge clk); #1;
    bus.i_valid = 1'b0; bus.i_flush = 1'b0;
    if (flush) chk("ready_in_flush", 64'(bus.o_ready), 64'(0));
  endtask

  task automatic flush_only();
    int n = 0;
    bus.i_valid = 1'b0;
    while (!bus.o_ready && n < 300) begin @(posedge clk); #1; n++; end
    bus.i_flush = 1'b1;
    done_seen = 1'b0;
    m_flush();
    @(posedge clk); #1;
    bus.i_flush = 1'b0;
    chk("ready_in_flush", 64'(bus.o_ready), 64'(0));
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done_seen && n < 500) begin @(posedge clk); #1; n++; end
    if (!done_seen) begin
      chk_cnt++;
      $display("FAIL flush_done_timeout: got no pulse expected one within 500 cycles");
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  // Downstream ready driver
  initial begin
    bus.i_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (hold_cnt > 0) begin
        bus.i_ready = 1'b0;
        hold_cnt--;
      end else if (rdy_mode == 1) bus.i_ready = ($urandom_range(0, 3) != 0);
      else bus.i_ready = 1'b1;
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
      done_prev  = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 64'(bus.o_valid), 64'(1));
        chk("hold_word", 64'({bus.o_last, bus.o_word}), 64'(prev_out));
      end
      if (done_prev) chk("total_cleared", 64'(bus.o_bits_total), 64'(0));
      if (bus.o_valid && bus.i_ready) begin
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL extra_word: got %0h expected no word", {bus.o_last, bus.o_word});
        end else chk("word_last", 64'({bus.o_last, bus.o_word}), 64'(exp_q.pop_front()));
      end
      if (bus.o_flush_done) begin
        if (done_prev) begin
          chk_cnt++;
          $display("FAIL done_width: got 2+ cycle pulse expected 1 cycle");
        end
        chk("ready_in_done", 64'(bus.o_ready), 64'(0));
        chk("valid_in_done", 64'(bus.o_valid), 64'(0));
        if (exp_tot.size() == 0) begin
          chk_cnt++;
          $display("FAIL extra_flush_done: got pulse expected none");
        end else chk("flush_total", 64'(bus.o_bits_total), 64'(exp_tot.pop_front()));
        chk("drained_at_done", 64'(exp_q.size()), 64'(0));
        done_seen = 1'b1;
      end
      stall_prev = bus.o_valid && !bus.i_ready;
      prev_out   = {bus.o_last, bus.o_word};
      done_prev  = bus.o_flush_done;
    end
  end

  initial begin
    bus.i_valid = 1'b0; bus.i_code = '0; bus.i_code_len = '0; bus.i_flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(bus.o_valid), 64'(0));
    chk("rst_ready", 64'(bus.o_ready), 64'(1));
    chk("rst_word", 64'(bus.o_word), 64'(0));
    chk("rst_last", 64'(bus.o_last), 64'(0));
    chk("rst_done", 64'(bus.o_flush_done), 64'(0));
    chk("rst_total", 64'(bus.o_bits_total), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset mid-stream with a stalled word pending
    hold_cnt = 1000;
    for (int i = 0; i < 6; i++) send(16'h00AB, 4'd8, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(bus.o_valid), 64'(0));
    chk("midrst_ready", 64'(bus.o_ready), 64'(1));
    chk("midrst_total", 64'(bus.o_bits_total), 64'(0));
    exp_q.delete(); exp_tot.delete(); bitq.delete(); m_tot = '0;
    hold_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 4 x 0xAB/8 -> ABABABAB with full-rate downstream
    for (int i = 0; i < 4; i++) send(16'h00AB, 4'd8, 1'b0);
    chk("total_32", 64'(bus.o_bits_total), 64'(32));
    flush_only();
    wait_done();

    // 3 x 15 ones, then flush: FFFFFFFF then FFF80000/last, total 45
    for (int i = 0; i < 3; i++) send(16'h7FFF, 4'd15, 1'b0);
    flush_only();
    wait_done();

    // Backpressure: 5 stalled cycles while more symbols are offered
    hold_cnt = 5;
    for (int i = 0; i < 4; i++) send(16'h00AB, 4'd8, 1'b0);
    for (int i = 0; i < 6; i++) send(16'h00CD, 4'd8, 1'b0);
    flush_only();
    wait_done();

    // Empty flush
    flush_only();
    wait_done();

    // len-0 mix; flush on the symbol that makes exactly 32 bits
    send(16'hFFFF, 4'd0, 1'b0);
    send(16'hF234, 4'd15, 1'b0);
    send(16'h1234, 4'd0, 1'b0);
    send(16'hD5A5, 4'd15, 1'b0);
    send(16'hFFFE, 4'd2, 1'b1);
    wait_done();

    // Randomized streams with random downstream ready
    rdy_mode = 1;
    for (int s = 0; s < 10; s++) begin
      int nsym = $urandom_range(5, 60);
      for (int k = 0; k < nsym; k++) begin
        bit fl = (k == nsym - 1) && ($urandom_range(0, 1) == 1);
        send(16'($urandom), 4'($urandom_range(0, 15)), fl);
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        if (fl) wait_done();
      end
      if (exp_tot.size() == 0 && done_seen) flush_only();
      else if (bitq.size() > 0 || exp_q.size() > 0 || m_tot != 0) flush_only();
      else flush_only();
      wait_done();
    end
    rdy_mode = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("final_words_drained", 64'(exp_q.size()), 64'(0));
    chk("final_flushes_drained", 64'(exp_tot.size()), 64'(0));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before 2ms");
    $fatal(1, "timeout");
  end
endmodule
